// File: rtl/alu_unit.sv
// alu_unit: single-cycle RV32I integer ALU with operand select and ROB/RRF write enables
module alu_unit #(
    parameter int ADDR_LEN        = 32,
    parameter int DATA_LEN        = 32,
    parameter int ALU_OP_WIDTH    = 4,
    parameter int SRC_A_SEL_WIDTH = 2,
    parameter int SRC_B_SEL_WIDTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       if_write_rrf_i,
    input  logic [ADDR_LEN-1:0]        pc_i,
    input  logic [DATA_LEN-1:0]        imm_i,
    input  logic [ALU_OP_WIDTH-1:0]    alu_op_i,
    input  logic [DATA_LEN-1:0]        src1_i,
    input  logic [SRC_A_SEL_WIDTH-1:0] src_a_select_i,
    input  logic [DATA_LEN-1:0]        src2_i,
    input  logic [SRC_B_SEL_WIDTH-1:0] src_b_select_i,
    input  logic                       issue_i,
    output logic [DATA_LEN-1:0]        result_o,
    output logic                       rob_we_o,
    output logic                       rrf_we_o
);
    localparam int SW = $clog2(DATA_LEN);
    localparam logic [ALU_OP_WIDTH-1:0] ADD = 0, SLL = 1, SEQ = 2, SNE = 3, XOR = 4, SRL = 5,
        OR = 6, AND = 7, SUB = 10, SRA = 11, SLT = 12, SGE = 13, SLTU = 14, SGEU = 15;

    logic [DATA_LEN-1:0] a, b, res;
    logic [SW-1:0]       sh;

    // operand selection and result computation
    always_comb begin
        a = src_a_select_i == 0 ? src1_i : src_a_select_i == 1 ? DATA_LEN'(pc_i) : '0;
        b = src_b_select_i == 0 ? src2_i : src_b_select_i == 1 ? imm_i :
            src_b_select_i == 2 ? DATA_LEN'(4) : '0;
        sh = b[SW-1:0];
        case (alu_op_i)
            ADD:     res = a + b;
            SLL:     res = a << sh;
            SEQ:     res = DATA_LEN'(a == b);
            SNE:     res = DATA_LEN'(a != b);
            XOR:     res = a ^ b;
            SRL:     res = a >> sh;
            OR:      res = a | b;
            AND:     res = a & b;
            SUB:     res = a - b;
            SRA:     res = $unsigned($signed(a) >>> sh);
            SLT:     res = DATA_LEN'($signed(a) < $signed(b));
            SGE:     res = DATA_LEN'($signed(a) >= $signed(b));
            SLTU:    res = DATA_LEN'(a < b);
            SGEU:    res = DATA_LEN'(a >= b);
            default: res = '0;
        endcase
        result_o = reset_i ? '0 : res;
        rob_we_o = !reset_i && issue_i;
        rrf_we_o = !reset_i && issue_i && if_write_rrf_i;
    end

    // reset sampled at each edge must never coincide with a write enable
    always_ff @(posedge clk_i) begin
        if (reset_i) assert (!rob_we_o && !rrf_we_o && result_o == '0);
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against an arithmetic reference model
module tb_alu_unit;
    logic        clk = 0;
    logic        reset, wr, iss;
    logic [31:0] pc, imm, s1, s2, result;
    logic [3:0]  op;
    logic [1:0]  asel, bsel;
    logic        rob_we, rrf_we;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    alu_unit dut (
        .clk_i(clk), .reset_i(reset), .if_write_rrf_i(wr), .pc_i(pc), .imm_i(imm),
        .alu_op_i(op), .src1_i(s1), .src_a_select_i(asel), .src2_i(s2),
        .src_b_select_i(bsel), .issue_i(iss), .result_o(result),
        .rob_we_o(rob_we), .rrf_we_o(rrf_we)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] o, input logic [1:0] as, input logic [1:0] bs,
                                          input logic [31:0] a1, input logic [31:0] a2,
                                          input logic [31:0] im, input logic [31:0] p);
        longint a, b, sa, sb, r, d, two32;
        two32 = longint'(1) << 32;
        a = as == 0 ? longint'({32'h0, a1}) : as == 1 ? longint'({32'h0, p}) : 0;
        b = bs == 0 ? longint'({32'h0, a2}) : bs == 1 ? longint'({32'h0, im}) : bs == 2 ? 4 : 0;
        sa = a >= (two32 / 2) ? a - two32 : a;
        sb = b >= (two32 / 2) ? b - two32 : b;
        d = longint'(1) << (b % 32);
        case (o)
            0:  r = a + b;
            1:  r = a * d;
            2:  r = (a == b) ? 1 : 0;
            3:  r = (a != b) ? 1 : 0;
            4:  r = a ^ b;
            5:  r = a / d;
            6:  r = a | b;
            7:  r = a & b;
            10: r = a - b;
            11: begin
                r = sa / d;
                if (sa < 0 && sa % d != 0) r = r - 1;
            end
            12: r = (sa < sb) ? 1 : 0;
            13: r = (sa >= sb) ? 1 : 0;
            14: r = (a < b) ? 1 : 0;
            15: r = (a >= b) ? 1 : 0;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic drive(input logic [3:0] o, input logic [1:0] as, input logic [1:0] bs,
                         input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] im,
                         input logic [31:0] p, input logic w, input logic i);
        @(posedge clk);
        #1;
        op = o; asel = as; bsel = bs; s1 = a1; s2 = a2; imm = im; pc = p; wr = w; iss = i;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] r, input logic rob, input logic rrf);
        check({tag, "_res"}, result, r);
        check({tag, "_rob"}, {31'b0, rob_we}, {31'b0, rob});
        check({tag, "_rrf"}, {31'b0, rrf_we}, {31'b0, rrf});
    endtask

    initial begin
        reset = 1;
        drive(0, 0, 0, 10, 12, 0, 0, 1, 1);
        expect_out("reset", 0, 0, 0);
        @(posedge clk);
        #1 reset = 0;
        drive(0, 0, 0, 10, 12, 0, 0, 1, 1);
        expect_out("add", 22, 1, 1);
        @(posedge clk);
        #1 reset = 1;
        #1 expect_out("mid_reset", 0, 0, 0);
        @(posedge clk);
        #1 reset = 0;
        drive(10, 0, 0, 5, 7, 0, 0, 1, 1);
        expect_out("sub", 32'hFFFFFFFE, 1, 1);
        drive(12, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1);
        expect_out("slt", 1, 1, 1);
        drive(14, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1);
        expect_out("sltu", 0, 1, 1);
        drive(15, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1);
        expect_out("sgeu", 1, 1, 1);
        drive(11, 0, 1, 32'h80000000, 0, 32'h24, 0, 1, 1);
        expect_out("sra", 32'hF8000000, 1, 1);
        drive(5, 0, 1, 32'h80000000, 0, 32'h24, 0, 1, 1);
        expect_out("srl", 32'h08000000, 1, 1);
        drive(1, 0, 1, 1, 0, 31, 0, 1, 1);
        expect_out("sll", 32'h80000000, 1, 1);
        drive(0, 1, 2, 0, 0, 0, 32'h100, 1, 1);
        expect_out("pc4", 32'h104, 1, 1);
        drive(0, 1, 2, 0, 0, 0, 32'h100, 0, 1);
        expect_out("pc4_nowr", 32'h104, 1, 0);
        drive(0, 0, 1, 32'hFFFFFFFF, 0, 1, 0, 1, 1);
        expect_out("add_wrap", 0, 1, 1);
        drive(10, 2, 1, 32'h1234, 0, 1, 0, 1, 1);
        expect_out("sub_zero", 32'hFFFFFFFF, 1, 1);
        drive(8, 0, 0, 3, 4, 0, 0, 1, 1);
        expect_out("undef8", 0, 1, 1);
        drive(4, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 1, 0);
        expect_out("noissue", 32'hFF00, 0, 0);
        drive(4, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 1, 1);
        expect_out("xor", 32'hFF00, 1, 1);
        drive(6, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 1, 1);
        expect_out("or", 32'hFFF0, 1, 1);
        drive(7, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 1, 1);
        expect_out("and", 32'h00F0, 1, 1);
        drive(2, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 1, 1);
        expect_out("seq", 0, 1, 1);
        drive(3, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 1, 1);
        expect_out("sne", 1, 1, 1);
        for (int n = 0; n < 300; n++) begin
            logic [3:0]  ro;
            logic [1:0]  ra, rb;
            logic [31:0] v1, v2, vi, vp;
            logic        rw, ri, rr;
            ro = 4'($urandom); ra = 2'($urandom); rb = 2'($urandom);
            v1 = $urandom; v2 = ($urandom_range(0, 3) == 0) ? v1 : $urandom;
            vi = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            vp = $urandom; rw = 1'($urandom); ri = 1'($urandom);
            rr = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1 reset = rr;
            drive(ro, ra, rb, v1, v2, vi, vp, rw, ri);
            expect_out($sformatf("rnd%0d_op%0d", n, ro), rr ? 32'h0 : model(ro, ra, rb, v1, v2, vi, vp),
                       !rr && ri, !rr && ri && rw);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
